// File: rtl/spi_axi_master_mc.sv
// AXI4-lite write-to-SPI bridge with multiple chip selects and full-duplex read-back.
// Each accepted write is shifted out MSB first on DATA under the selected CEB line.
// The MISO word captured during the same frame is returned on the AXI read channel.
module spi_axi_master_mc #(
  parameter int unsigned SWORD = 32,
  parameter int unsigned NCS   = 4,
  parameter int unsigned DIV   = 2,
  parameter bit          CPOL  = 1'b0,
  parameter bit          CPHA  = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             axi_awvalid,
  output logic             axi_awready,
  input  logic [SWORD-1:0] axi_awaddr,
  input  logic [2:0]       axi_awprot,
  input  logic             axi_wvalid,
  output logic             axi_wready,
  input  logic [SWORD-1:0] axi_wdata,
  input  logic [3:0]       axi_wstrb,
  output logic             axi_bvalid,
  input  logic             axi_bready,
  input  logic             axi_arvalid,
  output logic             axi_arready,
  input  logic [SWORD-1:0] axi_araddr,
  input  logic [2:0]       axi_arprot,
  output logic             axi_rvalid,
  input  logic             axi_rready,
  output logic [SWORD-1:0] axi_rdata,
  output logic             SCLK,
  output logic [NCS-1:0]   CEB,
  output logic             DATA,
  input  logic             MISO
);

  localparam int unsigned    CHW        = (NCS > 1) ? $clog2(NCS) : 1;
  localparam int unsigned    CW         = $clog2(DIV) + 1;
  localparam int unsigned    HW         = $clog2(2 * SWORD) + 1;
  localparam logic [CW-1:0]  CNT_END    = CW'(DIV - 1);
  localparam logic [HW-1:0]  LAST_HALF  = HW'(2 * SWORD - 1);
  localparam logic [HW-1:0]  LAST_TRAIL = HW'(2 * SWORD - 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_BRESP, ST_RRESP
  } state_t;

  state_t           r_state;
  logic             r_awready, r_wready, r_arready, r_bvalid, r_rvalid;
  logic [NCS-1:0]   r_ceb;
  logic             r_sclk, r_data;
  logic [CW-1:0]    r_cnt;
  logic [HW-1:0]    r_half;
  logic [SWORD-1:0] r_tx, r_rx, r_rdata;

  logic             w_go, w_load, w_tick, w_lead, w_trail, w_end, w_sample, w_shift;
  logic [CHW-1:0]   w_idx;
  logic             w_unused;

  assign w_unused = ^{axi_awprot, axi_araddr, axi_arprot};

  // Out-of-range channel or empty strobe still completes the write, just without a frame.
  assign w_go   = (axi_wstrb != 4'b0000) && ((axi_awaddr >> 2) < SWORD'(NCS));
  assign w_idx  = axi_awaddr[CHW+1:2];
  assign w_load = (r_state == ST_IDLE) && r_awready && w_go;

  // SCLK edge strobes: a leading edge ends SETUP and every odd half-period of SHIFT
  // except the final one, which is the idle tail before HOLD.
  assign w_tick   = (r_cnt == CNT_END);
  assign w_lead   = w_tick && ((r_state == ST_SETUP) ||
                    ((r_state == ST_SHIFT) && r_half[0] && (r_half != LAST_HALF)));
  assign w_trail  = w_tick && (r_state == ST_SHIFT) && !r_half[0];
  assign w_end    = w_tick && (r_state == ST_HOLD);
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_shift  = CPHA ? w_lead  : (w_trail && (r_half != LAST_TRAIL));

  // Control FSM: AXI handshakes, chip select, SCLK generation and phase timing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_ceb     <= '1;
      r_sclk    <= CPOL;
      r_cnt     <= '0;
      r_half    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_awready) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_cnt     <= '0;
            r_half    <= '0;
            if (w_go) begin
              r_ceb   <= ~(NCS'(1) << w_idx);
              r_state <= ST_SETUP;
            end else begin
              r_state <= ST_BRESP;
            end
          end else if (r_arready) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_state   <= ST_RRESP;
          end else if (axi_awvalid && axi_wvalid) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end else if (axi_arvalid) begin
            r_arready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_sclk  <= ~CPOL;
            r_state <= ST_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_half <= r_half + 1'b1;
            if (r_half == LAST_HALF) begin
              r_state <= ST_HOLD;
            end else begin
              r_sclk <= r_half[0] ? ~CPOL : CPOL;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_ceb   <= '1;
            r_state <= ST_BRESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_BRESP: begin
          if (!r_bvalid) begin
            r_bvalid <= 1'b1;
          end else if (axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_RRESP: begin
          if (axi_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Serial datapath: TX shifter driving DATA, RX shifter filling MSB first, read-back latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx    <= '0;
      r_rx    <= '0;
      r_data  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_load) begin
        r_rx <= '0;
        if (CPHA) begin
          r_tx <= axi_wdata;
        end else begin
          r_data <= axi_wdata[SWORD-1];
          r_tx   <= axi_wdata << 1;
        end
      end
      if (w_shift) begin
        r_data <= r_tx[SWORD-1];
        r_tx   <= {r_tx[SWORD-2:0], 1'b0};
      end
      if (w_sample) begin
        r_rx <= {r_rx[SWORD-2:0], MISO};
      end
      if (w_end) begin
        r_data  <= 1'b0;
        r_rdata <= r_rx;
      end
    end
  end

  assign axi_awready = r_awready;
  assign axi_wready  = r_wready;
  assign axi_bvalid  = r_bvalid;
  assign axi_arready = r_arready;
  assign axi_rvalid  = r_rvalid;
  assign axi_rdata   = r_rdata;
  assign SCLK        = r_sclk;
  assign CEB         = r_ceb;
  assign DATA        = r_data;

endmodule

// File: tb/tb_spi_axi_master_mc.sv
// Directed bench for spi_axi_master_mc: a 32-bit/4-CS/DIV=2 instance plus four
// 8-bit/DIV=3 instances covering every CPOL/CPHA mode, all with MISO looped to DATA.
module tb_spi_axi_master_mc;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Main instance
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, sclk, data;
  logic [31:0] rdata;
  logic [3:0]  ceb;

  spi_axi_master_mc #(.SWORD(32), .NCS(4), .DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_dut (
    .CLK(CLK), .RST(RST),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awprot(3'b000),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(32'h0), .axi_arprot(3'b000),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata),
    .SCLK(sclk), .CEB(ceb), .DATA(data), .MISO(data)
  );

  // Main-instance monitor; counters only grow, tests compare deltas.
  int          cyc = 0;
  int          ch_low [4];
  int          n_rise = 0, bv_cnt = 0, ar_cnt = 0, idle_bad = 0, t_ceb_up = 0, t_bv = 0;
  logic [31:0] cap = '0;
  logic        was_low = 1'b0, prev_sclk = 1'b0, prev_bv = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) if (!ceb[i]) ch_low[i]++;
    if (ceb != 4'hF) begin
      was_low = 1'b1;
      if (sclk && !prev_sclk) begin
        n_rise++;
        cap = {cap[30:0], data};
      end
    end else begin
      if (was_low) t_ceb_up = cyc;
      was_low = 1'b0;
      if (sclk || data) idle_bad++;
    end
    if (bvalid) bv_cnt++;
    if (arready) ar_cnt++;
    if (bvalid && !prev_bv) t_bv = cyc;
    prev_sclk = sclk;
    prev_bv   = bvalid;
  end

  // Mode-sweep instances, driven in lockstep
  logic       m_awvalid = 1'b0, m_wvalid = 1'b0, m_bready = 1'b0;
  logic [7:0] m_wdata = '0;
  logic [3:0] m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_sclk, m_data, m_ceb;

  for (genvar k = 0; k < 4; k++) begin : g_mode
    localparam bit P = ((k / 2) == 1);
    localparam bit H = ((k % 2) == 1);
    logic [7:0] rd;
    int         lead = 0, trail = 0, low = 0;
    logic       prev = P;

    spi_axi_master_mc #(.SWORD(8), .NCS(1), .DIV(3), .CPOL(P), .CPHA(H)) u_m (
      .CLK(CLK), .RST(RST),
      .axi_awvalid(m_awvalid), .axi_awready(m_awready[k]), .axi_awaddr(8'h00), .axi_awprot(3'b000),
      .axi_wvalid(m_wvalid), .axi_wready(m_wready[k]), .axi_wdata(m_wdata), .axi_wstrb(4'hF),
      .axi_bvalid(m_bvalid[k]), .axi_bready(m_bready),
      .axi_arvalid(1'b0), .axi_arready(m_arready[k]), .axi_araddr(8'h00), .axi_arprot(3'b000),
      .axi_rvalid(m_rvalid[k]), .axi_rready(1'b0), .axi_rdata(rd),
      .SCLK(m_sclk[k]), .CEB(m_ceb[k:k]), .DATA(m_data[k]), .MISO(m_data[k])
    );

    always @(negedge CLK) begin
      if (!m_ceb[k]) begin
        low++;
        if (m_sclk[k] != prev) begin
          if (m_sclk[k] == P) trail++;
          else lead++;
        end
      end
      prev = m_sclk[k];
    end

    task automatic chk();
      check_eq($sformatf("m%0d_lead", k), lead, 8);
      check_eq($sformatf("m%0d_trail", k), trail, 8);
      check_eq($sformatf("m%0d_ceb_low", k), low, 54);
      check_eq($sformatf("m%0d_loopback", k), 32'(rd), 32'h3C);
      check_eq($sformatf("m%0d_idle_sclk", k), 32'(m_sclk[k]), 32'(P));
      check_eq($sformatf("m%0d_no_read", k), 32'({m_arready[k], m_rvalid[k]}), 32'h0);
    endtask
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] strb, input int bdly);
    int n;
    awaddr = addr; wdata = d; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    check_eq("aw_accept", 32'(awready), 32'h1);
    check_eq("w_accept", 32'(wready), 32'h1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("aw_w_pulse", 32'({awready, wready}), 32'h0);
    n = 0;
    while (!bvalid && n < 2000) begin tick(); n++; end
    check_eq("bvalid_seen", 32'(bvalid), 32'h1);
    for (int i = 0; i < bdly; i++) begin
      check_eq("bvalid_hold", 32'(bvalid), 32'h1);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check_eq("bvalid_drop", 32'(bvalid), 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] exp, input int rdly);
    int n;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    check_eq("ar_accept", 32'(arready), 32'h1);
    tick();
    arvalid = 1'b0;
    check_eq("ar_pulse", 32'(arready), 32'h0);
    check_eq("rvalid_next", 32'(rvalid), 32'h1);
    check_eq("rdata", rdata, exp);
    for (int i = 0; i < rdly; i++) begin
      tick();
      check_eq("rvalid_hold", 32'(rvalid), 32'h1);
      check_eq("rdata_hold", rdata, exp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check_eq("rvalid_drop", 32'(rvalid), 32'h0);
  endtask

  int s[4];
  int r0, b0, a0, n;

  initial begin
    // Reset state
    RST = 1'b1;
    repeat (3) tick();
    check_eq("rst_ceb", 32'(ceb), 32'hF);
    check_eq("rst_sclk_data", 32'({sclk, data}), 32'h0);
    check_eq("rst_handshakes", 32'({awready, wready, arready, bvalid, rvalid}), 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_mode_sclk", 32'(m_sclk), 32'hC);
    RST = 1'b0;
    tick();

    // 1: default frame on CS0
    for (int i = 0; i < 4; i++) s[i] = ch_low[i];
    r0 = n_rise;
    axi_write(32'h0, 32'hA5C3_0F81, 4'hF, 0);
    check_eq("t1_ceb0_low", ch_low[0] - s[0], 132);
    check_eq("t1_sclk_rises", n_rise - r0, 32);
    check_eq("t1_mosi", cap, 32'hA5C3_0F81);
    check_eq("t1_bvalid_after_ceb", t_bv - t_ceb_up, 1);
    check_eq("t1_other_cs", (ch_low[1] - s[1]) + (ch_low[2] - s[2]) + (ch_low[3] - s[3]), 0);

    // 2: loopback read-back
    axi_write(32'h0, 32'h1234_5678, 4'hF, 0);
    axi_read(32'h1234_5678, 3);

    // 3: channel decode and suppressed transfers
    for (int i = 0; i < 4; i++) s[i] = ch_low[i];
    axi_write(32'h8, 32'hDEAD_BEEF, 4'hF, 2);
    check_eq("t3_cs2_low", ch_low[2] - s[2], 132);
    check_eq("t3_cs_others", (ch_low[0] - s[0]) + (ch_low[1] - s[1]) + (ch_low[3] - s[3]), 0);
    axi_read(32'hDEAD_BEEF, 0);
    for (int i = 0; i < 4; i++) s[i] = ch_low[i];
    r0 = n_rise;
    axi_write(32'h10, 32'h5555_AAAA, 4'hF, 0);
    axi_write(32'h0, 32'h1111_1111, 4'h0, 0);
    check_eq("t3_no_cs", (ch_low[0] - s[0]) + (ch_low[1] - s[1]) + (ch_low[2] - s[2]) + (ch_low[3] - s[3]), 0);
    check_eq("t3_no_sclk", n_rise - r0, 0);
    axi_read(32'hDEAD_BEEF, 0);

    // 4: all SPI modes, SWORD=8, DIV=3
    m_wdata = 8'h3C;
    m_awvalid = 1'b1; m_wvalid = 1'b1;
    n = 0;
    while (m_awready[0] !== 1'b1 && n < 50) begin tick(); n++; end
    check_eq("m_accept", 32'({m_awready, m_wready}), 32'hFF);
    tick();
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    n = 0;
    while (m_bvalid[0] !== 1'b1 && n < 500) begin tick(); n++; end
    check_eq("m_bvalid", 32'(m_bvalid), 32'hF);
    m_bready = 1'b1;
    tick();
    m_bready = 1'b0;
    g_mode[0].chk();
    g_mode[1].chk();
    g_mode[2].chk();
    g_mode[3].chk();

    // 5: reset mid-transfer aborts without a response
    b0 = bv_cnt;
    awaddr = 32'h4; wdata = 32'h0F0F_0F0F; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (40) tick();
    check_eq("t5_cs1_active", 32'(ceb), 32'hD);
    RST = 1'b1;
    tick();
    check_eq("t5_ceb_released", 32'(ceb), 32'hF);
    check_eq("t5_sclk_idle", 32'(sclk), 32'h0);
    RST = 1'b0;
    repeat (300) tick();
    check_eq("t5_no_bvalid", bv_cnt - b0, 0);
    axi_write(32'h0, 32'hCAFE_F00D, 4'hF, 0);
    check_eq("t5_mosi_after", cap, 32'hCAFE_F00D);
    axi_read(32'hCAFE_F00D, 0);

    // 6: write wins over a simultaneous read; delayed bready
    a0 = ar_cnt;
    arvalid = 1'b1;
    axi_write(32'h4, 32'h600D_F00D, 4'hF, 10);
    check_eq("t6_read_waited", ar_cnt - a0, 0);
    axi_read(32'h600D_F00D, 1);

    check_eq("idle_lines_quiet", idle_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
